// File: rtl/fractal_sync_mux_if.sv
// Bundle of the requester-side and upstream-side signals of fractal_sync_mux.
// The mux sits on the slave modport; whatever drives it uses the master modport.
interface fractal_sync_mux_if #(
  parameter int N_PORTS    = 4,
  parameter int AGGR_WIDTH = 1,
  parameter int ID_WIDTH   = 1
);
  logic [N_PORTS-1:0]                 slv_sync_i, slv_lock_i, slv_free_i;
  logic [N_PORTS-1:0][AGGR_WIDTH-1:0] slv_aggr_i;
  logic [N_PORTS-1:0][ID_WIDTH-1:0]   slv_id_i;
  logic [N_PORTS-1:0]                 slv_wake_o, slv_grant_o, slv_error_o;
  logic [AGGR_WIDTH-1:0]              slv_aggr_rsp_o;
  logic [ID_WIDTH-1:0]                slv_id_rsp_o;

  logic                               mst_sync_o, mst_lock_o, mst_free_o;
  logic [AGGR_WIDTH-1:0]              mst_aggr_o;
  logic [ID_WIDTH-1:0]                mst_id_o;
  logic                               mst_wake_i, mst_grant_i, mst_error_i;
  logic [AGGR_WIDTH-1:0]              mst_aggr_rsp_i;
  logic [ID_WIDTH-1:0]                mst_id_rsp_i;

  modport slave (
    input  slv_sync_i, slv_lock_i, slv_free_i, slv_aggr_i, slv_id_i,
    input  mst_wake_i, mst_grant_i, mst_error_i, mst_aggr_rsp_i, mst_id_rsp_i,
    output slv_wake_o, slv_grant_o, slv_error_o, slv_aggr_rsp_o, slv_id_rsp_o,
    output mst_sync_o, mst_lock_o, mst_free_o, mst_aggr_o, mst_id_o
  );

  modport master (
    output slv_sync_i, slv_lock_i, slv_free_i, slv_aggr_i, slv_id_i,
    output mst_wake_i, mst_grant_i, mst_error_i, mst_aggr_rsp_i, mst_id_rsp_i,
    input  slv_wake_o, slv_grant_o, slv_error_o, slv_aggr_rsp_o, slv_id_rsp_o,
    input  mst_sync_o, mst_lock_o, mst_free_o, mst_aggr_o, mst_id_o
  );
endinterface

// File: rtl/fractal_sync_mux.sv
// Round-robin mux of N_PORTS sync/lock/free requesters onto one upstream sync port,
// with per-port waiter tracking that steers wake/grant/error responses back.
module fractal_sync_mux_port #(
  parameter int AGGR_WIDTH = 1,
  parameter int ID_WIDTH   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sync_i,
  input  logic                  lock_i,
  input  logic                  free_i,
  input  logic [AGGR_WIDTH-1:0] aggr_i,
  input  logic [ID_WIDTH-1:0]   id_i,
  input  logic                  win_i,
  input  logic                  rsp_error_i,
  input  logic                  rsp_grant_i,
  input  logic                  rsp_wake_i,
  input  logic [AGGR_WIDTH-1:0] rsp_aggr_i,
  input  logic [ID_WIDTH-1:0]   rsp_id_i,
  output logic                  pend_o,
  output logic                  lock_match_o,
  output logic [1:0]            kind_o,
  output logic [AGGR_WIDTH-1:0] aggr_o,
  output logic [ID_WIDTH-1:0]   id_o,
  output logic                  wake_o,
  output logic                  grant_o,
  output logic                  error_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, WAIT = 2'd2} state_e;
  typedef enum logic [1:0] {K_SYNC = 2'd0, K_LOCK = 2'd1, K_FREE = 2'd2} kind_e;
  typedef struct packed {
    kind_e                 kind;
    logic [AGGR_WIDTH-1:0] aggr;
    logic [ID_WIDTH-1:0]   id;
  } slot_t;

  state_e state_q, state_d;
  slot_t  slot_q, slot_d;
  logic   any_req, multi_req, match, hit_err, hit_grant, hit_wake;
  logic   wake_d, grant_d, error_d;

  assign any_req   = sync_i | lock_i | free_i;
  assign multi_req = (sync_i & lock_i) | (sync_i & free_i) | (lock_i & free_i);
  // Only WAIT ports are eligible, so a PEND port whose forward is in flight never matches.
  assign match     = (state_q == WAIT) && (slot_q.aggr == rsp_aggr_i) && (slot_q.id == rsp_id_i);
  assign lock_match_o = match && (slot_q.kind == K_LOCK);
  assign hit_err   = rsp_error_i & match;
  assign hit_grant = rsp_grant_i & lock_match_o;
  assign hit_wake  = rsp_wake_i & match & (slot_q.kind == K_SYNC);

  assign pend_o = (state_q == PEND);
  assign kind_o = slot_q.kind;
  assign aggr_o = slot_q.aggr;
  assign id_o   = slot_q.id;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      slot_q  <= '0;
      wake_o  <= 1'b0;
      grant_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      wake_o  <= wake_d;
      grant_o <= grant_d;
      error_o <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: if (any_req && !multi_req) begin
        state_d     = PEND;
        slot_d.kind = sync_i ? K_SYNC : (lock_i ? K_LOCK : K_FREE);
        slot_d.aggr = aggr_i;
        slot_d.id   = id_i;
      end
      PEND: if (win_i) state_d = (slot_q.kind == K_FREE) ? IDLE : WAIT;
      WAIT: if (hit_err || hit_grant || hit_wake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    error_d = (any_req && (multi_req || state_q != IDLE)) || hit_err;
    grant_d = hit_grant;
    wake_d  = hit_wake;
  end
endmodule

module fractal_sync_mux #(
  parameter int N_PORTS    = 4,
  parameter int AGGR_WIDTH = 1,
  parameter int ID_WIDTH   = 1
) (
  input logic                clk_i,
  input logic                rst_ni,
  fractal_sync_mux_if.slave  bus
);
  localparam int PW = $clog2(N_PORTS);
  localparam int XW = PW + 1;
  localparam logic [1:0] K_SYNC = 2'd0, K_LOCK = 2'd1, K_FREE = 2'd2;

  logic [N_PORTS-1:0]                 pend, lock_match, lock_low, win, grant_sel;
  logic [N_PORTS-1:0][1:0]            kind;
  logic [N_PORTS-1:0][AGGR_WIDTH-1:0] aggr;
  logic [N_PORTS-1:0][ID_WIDTH-1:0]   id;
  logic [PW-1:0]                      rr_q, rr_d, widx;
  logic [XW-1:0]                      idx;
  logic                               found, wake_ev;

  // Responses are mutually exclusive by priority error > grant > wake.
  assign lock_low  = lock_match & (~lock_match + N_PORTS'(1));
  assign grant_sel = (bus.mst_grant_i && !bus.mst_error_i) ? lock_low : '0;
  assign wake_ev   = bus.mst_wake_i && !bus.mst_grant_i && !bus.mst_error_i;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    fractal_sync_mux_port #(.AGGR_WIDTH(AGGR_WIDTH), .ID_WIDTH(ID_WIDTH)) u_port (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .sync_i       (bus.slv_sync_i[p]),
      .lock_i       (bus.slv_lock_i[p]),
      .free_i       (bus.slv_free_i[p]),
      .aggr_i       (bus.slv_aggr_i[p]),
      .id_i         (bus.slv_id_i[p]),
      .win_i        (win[p]),
      .rsp_error_i  (bus.mst_error_i),
      .rsp_grant_i  (grant_sel[p]),
      .rsp_wake_i   (wake_ev),
      .rsp_aggr_i   (bus.mst_aggr_rsp_i),
      .rsp_id_i     (bus.mst_id_rsp_i),
      .pend_o       (pend[p]),
      .lock_match_o (lock_match[p]),
      .kind_o       (kind[p]),
      .aggr_o       (aggr[p]),
      .id_o         (id[p]),
      .wake_o       (bus.slv_wake_o[p]),
      .grant_o      (bus.slv_grant_o[p]),
      .error_o      (bus.slv_error_o[p])
    );
  end

  // First PEND port at or after rr_q, wrapping.
  always_comb begin
    found = 1'b0;
    widx  = '0;
    idx   = '0;
    win   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = {1'b0, rr_q} + XW'(k);
      if (idx >= XW'(N_PORTS)) idx = idx - XW'(N_PORTS);
      if (!found && pend[idx[PW-1:0]]) begin
        found = 1'b1;
        widx  = idx[PW-1:0];
      end
    end
    if (found) win[widx] = 1'b1;
    rr_d = rr_q;
    if (found) rr_d = (int'(widx) == N_PORTS - 1) ? '0 : widx + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q               <= '0;
      bus.mst_sync_o     <= 1'b0;
      bus.mst_lock_o     <= 1'b0;
      bus.mst_free_o     <= 1'b0;
      bus.mst_aggr_o     <= '0;
      bus.mst_id_o       <= '0;
      bus.slv_aggr_rsp_o <= '0;
      bus.slv_id_rsp_o   <= '0;
    end else begin
      rr_q               <= rr_d;
      bus.mst_sync_o     <= found && (kind[widx] == K_SYNC);
      bus.mst_lock_o     <= found && (kind[widx] == K_LOCK);
      bus.mst_free_o     <= found && (kind[widx] == K_FREE);
      bus.mst_aggr_o     <= found ? aggr[widx] : '0;
      bus.mst_id_o       <= found ? id[widx] : '0;
      bus.slv_aggr_rsp_o <= bus.mst_aggr_rsp_i;
      bus.slv_id_rsp_o   <= bus.mst_id_rsp_i;
    end
  end
endmodule

// File: tb/tb_fractal_sync_mux.sv
// Directed bench for fractal_sync_mux: capture, round-robin order, response steering,
// illegal requests, response priority and asynchronous reset.
module tb_fractal_sync_mux;
  localparam int N = 4, AW = 2, IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  fractal_sync_mux_if #(.N_PORTS(N), .AGGR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

  fractal_sync_mux #(.N_PORTS(N), .AGGR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr();
    bus.slv_sync_i = '0; bus.slv_lock_i = '0; bus.slv_free_i = '0;
    bus.slv_aggr_i = '0; bus.slv_id_i = '0;
    bus.mst_wake_i = 1'b0; bus.mst_grant_i = 1'b0; bus.mst_error_i = 1'b0;
    bus.mst_aggr_rsp_i = '0; bus.mst_id_rsp_i = '0;
  endtask

  // kind: 0 sync, 1 lock, 2 free, 3 sync+lock
  task automatic req(input int p, input int kind, input int a, input int i);
    logic [1:0] pp;
    pp = p[1:0];
    if (kind == 0 || kind == 3) bus.slv_sync_i[pp] = 1'b1;
    if (kind == 1 || kind == 3) bus.slv_lock_i[pp] = 1'b1;
    if (kind == 2) bus.slv_free_i[pp] = 1'b1;
    bus.slv_aggr_i[pp] = a[AW-1:0];
    bus.slv_id_i[pp]   = i[IW-1:0];
  endtask

  task automatic rsp(input logic w, input logic g, input logic e, input int a, input int i);
    bus.mst_wake_i = w; bus.mst_grant_i = g; bus.mst_error_i = e;
    bus.mst_aggr_rsp_i = a[AW-1:0];
    bus.mst_id_rsp_i   = i[IW-1:0];
  endtask

  // {sync,lock,free}: 4 = sync, 2 = lock, 1 = free
  function automatic int mst();
    return int'({bus.mst_sync_o, bus.mst_lock_o, bus.mst_free_o});
  endfunction

  initial begin
    clr();
    #1 rst_n = 1'b0;
    repeat (2) step();
    chk("rst_mst", int'({bus.mst_sync_o, bus.mst_lock_o, bus.mst_free_o, bus.mst_aggr_o, bus.mst_id_o}), 0);
    chk("rst_slv", int'({bus.slv_wake_o, bus.slv_grant_o, bus.slv_error_o, bus.slv_aggr_rsp_o, bus.slv_id_rsp_o}), 0);
    rst_n = 1'b1;
    step();

    // all four lock at once, rr_ptr = 0: served 0,1,2,3
    for (int p = 0; p < N; p++) req(p, 1, p, 1);
    step(); clr();
    chk("lock_lat1", mst(), 0);
    for (int k = 0; k < N; k++) begin
      step();
      chk("rr0_lock", int'(bus.mst_lock_o), 1);
      chk("rr0_order", int'(bus.mst_aggr_o), k);
    end
    step();
    chk("rr0_done", mst(), 0);
    for (int p = 0; p < N; p++) begin
      rsp(1'b0, 1'b0, 1'b1, p, 1); step(); clr();
      chk("err_release", int'(bus.slv_error_o), 1 << p);
    end

    // port 1 sync, 2-cycle latency, then wake
    req(1, 0, 1, 0); step(); clr();
    chk("sync_c1", mst(), 0);
    step();
    chk("sync_c2", mst(), 4);
    chk("sync_aggr", int'(bus.mst_aggr_o), 1);
    chk("sync_id", int'(bus.mst_id_o), 0);
    rsp(1'b1, 1'b0, 1'b0, 1, 0); step(); clr();
    chk("wake1", int'(bus.slv_wake_o), 2);
    chk("wake1_aggr", int'(bus.slv_aggr_rsp_o), 1);
    step();
    chk("wake1_pulse", int'(bus.slv_wake_o), 0);

    // second round with rr_ptr = 2: served 2,3,0,1
    for (int p = 0; p < N; p++) req(p, 1, p, p);
    step(); clr();
    for (int k = 0; k < N; k++) begin
      step();
      chk("rr2_order", int'(bus.mst_aggr_o), (k + 2) % N);
      chk("rr2_id", int'(bus.mst_id_o), (k + 2) % N);
    end
    step();
    for (int p = 0; p < N; p++) begin
      rsp(1'b0, 1'b1, 1'b0, p, p); step(); clr();
      chk("grant_release", int'(bus.slv_grant_o), 1 << p);
    end

    // ports 0 and 2 lock on the same aggr/id: grants go lowest index first
    req(0, 1, 3, 2); req(2, 1, 3, 2); step(); clr();
    step(); chk("dup_fwd_a", mst(), 2);
    step(); chk("dup_fwd_b", mst(), 2);
    step();
    rsp(1'b0, 1'b1, 1'b0, 3, 2); step(); clr();
    chk("grant_low", int'(bus.slv_grant_o), 1);
    rsp(1'b0, 1'b1, 1'b0, 3, 2); step(); clr();
    chk("grant_next", int'(bus.slv_grant_o), 4);

    // illegal: sync+lock on port 3
    req(3, 3, 0, 0); step(); clr();
    chk("multi_err", int'(bus.slv_error_o), 8);
    chk("multi_mst", mst(), 0);
    step();
    chk("multi_drop", mst(), 0);
    chk("multi_err_pulse", int'(bus.slv_error_o), 0);

    // illegal: port 0 requests while in WAIT, still woken later
    req(0, 0, 1, 1); step(); clr(); step();
    chk("wait_fwd", mst(), 4);
    req(0, 0, 1, 1); step(); clr();
    chk("busy_err", int'(bus.slv_error_o), 1);
    rsp(1'b1, 1'b0, 1'b0, 1, 1); step(); clr();
    chk("busy_wake", int'(bus.slv_wake_o), 1);
    chk("busy_no_fwd", mst(), 0);

    // free, then immediate reuse of port 2
    req(2, 2, 2, 3); step(); clr(); step();
    chk("free_fwd", mst(), 1);
    chk("free_aggr", int'(bus.mst_aggr_o), 2);
    chk("free_id", int'(bus.mst_id_o), 3);
    req(2, 0, 2, 1); step(); clr();
    chk("reuse_accept", int'(bus.slv_error_o), 0);
    step();
    chk("reuse_fwd", mst(), 4);
    chk("reuse_id", int'(bus.mst_id_o), 1);
    rsp(1'b1, 1'b0, 1'b0, 2, 2); step(); clr();
    chk("nomatch_wake", int'(bus.slv_wake_o), 0);
    chk("nomatch_id_rsp", int'(bus.slv_id_rsp_o), 2);
    rsp(1'b1, 1'b0, 1'b0, 2, 1); step(); clr();
    chk("match_wake", int'(bus.slv_wake_o), 4);

    // wake and error together: error wins
    req(1, 0, 0, 0); step(); clr(); step();
    chk("prio_fwd", mst(), 4);
    rsp(1'b1, 1'b0, 1'b1, 0, 0); step(); clr();
    chk("prio_err", int'(bus.slv_error_o), 2);
    chk("prio_wake", int'(bus.slv_wake_o), 0);

    // reset with port 0 in WAIT and port 1 in PEND
    req(0, 1, 1, 0); step(); clr();
    req(1, 0, 1, 0); step(); clr();
    chk("pre_rst_fwd", mst(), 2);
    rst_n = 1'b0;
    #1;
    chk("rst_async_mst", int'({bus.mst_sync_o, bus.mst_lock_o, bus.mst_free_o, bus.mst_aggr_o, bus.mst_id_o}), 0);
    chk("rst_async_slv", int'({bus.slv_wake_o, bus.slv_grant_o, bus.slv_error_o, bus.slv_aggr_rsp_o, bus.slv_id_rsp_o}), 0);
    step();
    rst_n = 1'b1;
    rsp(1'b1, 1'b1, 1'b0, 1, 0); step(); clr();
    chk("post_rst_rsp", int'({bus.slv_wake_o, bus.slv_grant_o}), 0);
    chk("post_rst_mst", mst(), 0);
    req(0, 0, 1, 0); req(3, 0, 3, 0); step(); clr();
    chk("post_rst_lat1", mst(), 0);
    step();
    chk("post_rst_first", mst(), 4);
    chk("post_rst_first_aggr", int'(bus.mst_aggr_o), 1);
    step();
    chk("post_rst_second_aggr", int'(bus.mst_aggr_o), 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
